// File: rtl/frame_writer.sv
// Pixel-stream sink: raster tracking, centroid marker overlay in the ROI band, frame-buffer write port.
// One-cycle latency from in_ready to wr_en; accepts a pixel every cycle and never stalls upstream.
module frame_writer #(
    parameter int          IMG_W         = 640,
    parameter int          IMG_H         = 480,
    parameter int          ROI_HEIGHT    = 64,
    parameter int          MARKER_HALF_W = 1,
    parameter logic [11:0] MARKER_COLOR  = 12'hF00
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [11:0]                      pixel_in,
    input  logic                             in_ready,
    input  logic                             sof,
    input  logic [$clog2(IMG_W):0]           centroid_x,
    input  logic                             centroid_rdy,
    input  logic                             line_lost,
    output logic                             wr_en,
    output logic [$clog2(IMG_W*IMG_H)-1:0]   wr_addr,
    output logic [11:0]                      wr_data,
    output logic                             frame_done,
    output logic [15:0]                      frame_count,
    output logic                             sync_err
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW = $clog2(IMG_W * IMG_H);
    localparam int CW = $clog2(IMG_W) + 1;

    localparam logic [XW-1:0]        X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]        Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0]        Y_BAND = YW'(IMG_H - ROI_HEIGHT);
    localparam logic [CW-1:0]        X_LIM  = CW'(IMG_W);
    localparam logic signed [CW:0]   HALF_W = (CW + 1)'(MARKER_HALF_W);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] addr;

    logic          pend_vld;
    logic          pend_lost;
    logic [CW-1:0] pend_x;
    logic          act_vld;
    logic          act_lost;
    logic [CW-1:0] act_x;

    logic          at_origin;
    logic          frame_start;
    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic [AW-1:0] addr_cur;
    logic          x_last;
    logic          last_pix;
    logic          use_vld;
    logic          use_lost;
    logic [CW-1:0] use_x;
    logic signed [CW:0] dx;
    logic          marker_hit;

    // sof forces the counters to the origin before this pixel is placed.
    always_comb begin
        at_origin   = (x == '0) && (y == '0);
        frame_start = (state == ST_IDLE) || sof || at_origin;
        x_cur       = sof ? '0 : x;
        y_cur       = sof ? '0 : y;
        addr_cur    = sof ? '0 : addr;
        x_last      = (x_cur == X_LAST);
        last_pix    = x_last && (y_cur == Y_LAST);
    end

    // The first pixel of a frame already sees the freshly copied centroid, not a same-cycle update.
    always_comb begin
        use_vld    = frame_start ? pend_vld  : act_vld;
        use_lost   = frame_start ? pend_lost : act_lost;
        use_x      = frame_start ? pend_x    : act_x;
        dx         = $signed((CW + 1)'(x_cur)) - $signed((CW + 1)'(use_x));
        marker_hit = use_vld && !use_lost
                  && (y_cur >= Y_BAND)
                  && (use_x < X_LIM)
                  && (dx <= HALF_W) && (dx >= -HALF_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
        end else if (in_ready) begin
            state <= ST_RUN;
            if (last_pix) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else begin
                x    <= x_last ? '0 : x_cur + 1'b1;
                y    <= x_last ? y_cur + 1'b1 : y_cur;
                addr <= addr_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld  <= 1'b0;
            pend_lost <= 1'b0;
            pend_x    <= '0;
            act_vld   <= 1'b0;
            act_lost  <= 1'b0;
            act_x     <= '0;
        end else begin
            if (centroid_rdy) begin
                pend_vld  <= 1'b1;
                pend_lost <= line_lost;
                pend_x    <= centroid_x;
            end
            if (in_ready && frame_start) begin
                act_vld  <= pend_vld;
                act_lost <= pend_lost;
                act_x    <= pend_x;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            sync_err    <= 1'b0;
        end else begin
            wr_en      <= in_ready;
            frame_done <= in_ready && last_pix;
            if (in_ready) begin
                wr_addr <= addr_cur;
                wr_data <= marker_hit ? MARKER_COLOR : pixel_in;
                if (last_pix)
                    frame_count <= frame_count + 16'd1;
                if (sof && !at_origin)
                    sync_err <= 1'b1;
            end
        end
    end

endmodule
